// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry skid buffer feeding the register file, plus NZCV.
// Optional sticky overflow output enabled by defining ALU_WB_STICKY_OVF_EN.
module alu_writeback_stage #(
   parameter int WIDTH      = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_result,
   input  logic                  in_c_out,
   input  logic                  in_negative,
   input  logic                  in_overflow,
   input  logic [REG_ADDR_W-1:0] in_dest,
   input  logic                  in_flag_we,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_result,
   output logic [REG_ADDR_W-1:0] out_dest,
   output logic [3:0]            flags,
`ifdef ALU_WB_STICKY_OVF_EN
   output logic                  sticky_v,
`endif
   input  logic                  clr_sticky
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [WIDTH-1:0]      main_res_q, main_res_d;
   logic [REG_ADDR_W-1:0] main_dest_q, main_dest_d;
   logic [WIDTH-1:0]      skid_res_q, skid_res_d;
   logic [REG_ADDR_W-1:0] skid_dest_q, skid_dest_d;
   logic [3:0]            flags_q, flags_d;
   logic                  accept;
   logic                  xfer;

   assign in_ready   = (state_q != S_TWO);
   assign out_valid  = (state_q == S_ONE) || (state_q == S_TWO);
   assign out_result = main_res_q;
   assign out_dest   = main_dest_q;
   assign flags      = flags_q;
   assign accept     = in_valid && in_ready;
   assign xfer       = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      main_res_d  = main_res_q;
      main_dest_d = main_dest_q;
      skid_res_d  = skid_res_q;
      skid_dest_d = skid_dest_q;
      unique case (state_q)
         S_EMPTY: begin
            if (accept) begin
               main_res_d  = in_result;
               main_dest_d = in_dest;
               state_d     = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && xfer) begin
               main_res_d  = in_result;
               main_dest_d = in_dest;
            end else if (accept) begin
               skid_res_d  = in_result;
               skid_dest_d = in_dest;
               state_d     = S_TWO;
            end else if (xfer) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (xfer) begin
               main_res_d  = skid_res_q;
               main_dest_d = skid_dest_q;
               state_d     = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // Flags follow acceptance order, regardless of downstream stall.
   always_comb begin
      flags_d = flags_q;
      if (accept && in_flag_we)
         flags_d = {in_negative, (in_result == '0), in_c_out, in_overflow};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         main_res_q  <= '0;
         main_dest_q <= '0;
         skid_res_q  <= '0;
         skid_dest_q <= '0;
         flags_q     <= 4'b0000;
      end else begin
         state_q     <= state_d;
         main_res_q  <= main_res_d;
         main_dest_q <= main_dest_d;
         skid_res_q  <= skid_res_d;
         skid_dest_q <= skid_dest_d;
         flags_q     <= flags_d;
      end
   end

`ifdef ALU_WB_STICKY_OVF_EN
   logic sticky_q, sticky_d;

   // A setting accept wins over a simultaneous clear.
   always_comb begin
      sticky_d = sticky_q;
      if (clr_sticky)
         sticky_d = 1'b0;
      if (accept && in_flag_we && in_overflow)
         sticky_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) sticky_q <= 1'b0;
      else     sticky_q <= sticky_d;
   end

   assign sticky_v = sticky_q;
`else
   logic unused_clr_sticky;
   assign unused_clr_sticky = clr_sticky;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed testbench for alu_writeback_stage.
// Sticky overflow checks run only when ALU_WB_STICKY_OVF_EN is defined.
module tb_alu_writeback_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_result;
   logic       in_c_out;
   logic       in_negative;
   logic       in_overflow;
   logic [2:0] in_dest;
   logic       in_flag_we;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic [2:0] out_dest;
   logic [3:0] flags;
   logic       clr_sticky;
`ifdef ALU_WB_STICKY_OVF_EN
   logic       sticky_v;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_writeback_stage #(.WIDTH(8), .REG_ADDR_W(3)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_result(in_result),
      .in_c_out(in_c_out),
      .in_negative(in_negative),
      .in_overflow(in_overflow),
      .in_dest(in_dest),
      .in_flag_we(in_flag_we),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_result(out_result),
      .out_dest(out_dest),
      .flags(flags),
`ifdef ALU_WB_STICKY_OVF_EN
      .sticky_v(sticky_v),
`endif
      .clr_sticky(clr_sticky)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] r, input logic c, input logic n,
                        input logic v, input logic [2:0] d, input logic we);
      in_valid    = 1'b1;
      in_result   = r;
      in_c_out    = c;
      in_negative = n;
      in_overflow = v;
      in_dest     = d;
      in_flag_we  = we;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_result = '0;
      in_c_out = 1'b0;
      in_negative = 1'b0;
      in_overflow = 1'b0;
      in_dest = '0;
      in_flag_we = 1'b0;
      out_ready = 1'b1;
      clr_sticky = 1'b0;

      drive(8'hFF, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1);
      tick();
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_flags", 32'(flags), 32'h0);
      chk("rst_out_result", 32'(out_result), 32'h0);
      chk("rst_out_dest", 32'(out_dest), 32'h0);

      // Single op with zero result
      drive(8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_result", 32'(out_result), 32'h00);
      chk("single_dest", 32'(out_dest), 32'd3);
      chk("single_flags", 32'(flags), 32'b0110);
      tick();
      chk("single_drain", 32'(out_valid), 32'd0);

      // Back-to-back stream
      for (int i = 1; i <= 16; i++) begin
         drive(8'(i), 1'b0, 1'b0, 1'b0, 3'(i), 1'b0);
         chk("stream_in_ready", 32'(in_ready), 32'd1);
         tick();
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_result", 32'(out_result), 32'(i));
         chk("stream_dest", 32'(out_dest), 32'(i % 8));
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain", 32'(out_valid), 32'd0);
      chk("stream_flags_kept", 32'(flags), 32'b0110);

      // Backpressure
      out_ready = 1'b0;
      drive(8'hA5, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
      tick();
      chk("bp_first", 32'(out_result), 32'hA5);
      chk("bp_ready1", 32'(in_ready), 32'd1);
      drive(8'h5A, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("bp_ready0", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'(out_result), 32'hA5);
      tick();
      chk("bp_hold2", 32'(out_result), 32'hA5);
      chk("bp_hold_dest", 32'(out_dest), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_second", 32'(out_result), 32'h5A);
      chk("bp_second_dest", 32'(out_dest), 32'd2);
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      chk("bp_valid", 32'(out_valid), 32'd1);
      tick();
      chk("bp_drain", 32'(out_valid), 32'd0);

      // Overflow flag alone
      drive(8'h7F, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("v_flags", 32'(flags), 32'b0001);
      tick();

      // Flags under stall, then reset in TWO
      out_ready = 1'b0;
      drive(8'h80, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1);
      tick();
      chk("fl_first", 32'(flags), 32'b1000);
      drive(8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0);
      tick();
      chk("fl_second", 32'(flags), 32'b1000);
      chk("fl_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_flags", 32'(flags), 32'h0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_result", 32'(out_result), 32'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid_rst_no_ghost", 32'(out_valid), 32'd0);
      end

`ifdef ALU_WB_STICKY_OVF_EN
      chk("sticky_rst", 32'(sticky_v), 32'd0);
      drive(8'h80, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1);
      tick();
      chk("sticky_set", 32'(sticky_v), 32'd1);
      drive(8'h01, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
      tick();
      chk("sticky_keep", 32'(sticky_v), 32'd1);
      drive(8'h81, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1);
      clr_sticky = 1'b1;
      tick();
      chk("sticky_set_wins", 32'(sticky_v), 32'd1);
      in_valid = 1'b0;
      tick();
      clr_sticky = 1'b0;
      chk("sticky_clr", 32'(sticky_v), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
